spike_encoder: RTL and testbench

- Generates the per-PE spike trains that the compute unit consumes on its input-spike bus.
- Accepts one 8-bit pixel/activation per PE through a valid/ready handshake.
- Encodes each value into a T_STEPS-bit spike train, either rate-coded or time-to-first-spike.
- Holds the finished trains with a valid/ready handshake until the CU side takes them.

---
 rtl/spike_encoder_if.sv | 24 ++
 rtl/spike_encoder.sv | 94 +++++++++
 tb/tb_spike_encoder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/spike_encoder_if.sv
// Handshake bundle between the pixel source, the spike encoder and the CU spike consumer.
interface spike_encoder_if #(
  parameter int NUM_PES = 4,
  parameter int T_STEPS = 8
) ();
  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_PES-1:0][7:0]           pixels;
  logic                              enc_mode;
  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_PES-1:0][T_STEPS-1:0]   out_spikes;
  logic                              busy;

  modport master (
    output in_valid, pixels, enc_mode, out_ready,
    input  in_ready, out_valid, out_spikes, busy
  );

  modport slave (
    input  in_valid, pixels, enc_mode, out_ready,
    output in_ready, out_valid, out_spikes, busy
  );
endinterface

// File: rtl/spike_encoder.sv
// Encodes one 8-bit value per PE lane into a T_STEPS-bit spike train (rate or
// time-to-first-spike) and holds the trains until the consumer takes them.
module spike_encoder #(
  parameter int NUM_PES = 4,
  parameter int T_STEPS = 8
) (
  input  logic            clk,
  input  logic            nrst,
  spike_encoder_if.slave  bus
);
  localparam int TW  = $clog2(T_STEPS);
  localparam int SHR = (TW <= 8) ? (8 - TW) : 0;
  localparam int SHL = (TW > 8) ? (TW - 8) : 0;
  localparam logic [TW-1:0] LAST_STEP = TW'(T_STEPS - 1);

  typedef enum logic [1:0] {IDLE, ENCODE, HOLD} state_t;

  state_t                           state, state_next;
  logic [TW-1:0]                    step;
  logic [NUM_PES-1:0][7:0]          pix_q;
  logic [NUM_PES-1:0][7:0]          acc;
  logic                             mode_q;
  logic [NUM_PES-1:0][T_STEPS-1:0]  spikes;
  logic [NUM_PES-1:0][8:0]          sum;
  logic [NUM_PES-1:0]               spike_bit;

  // Inverted value scaled onto the step range: brighter pixels fire earlier.
  function automatic logic [TW-1:0] ttfs_step(input logic [7:0] p);
    logic [7:0] inv;
    inv = ~p;
    return TW'(inv >> SHR) << SHL;
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)      state_next = ENCODE;
      ENCODE:  if (step == LAST_STEP) state_next = HOLD;
      HOLD:    if (bus.out_ready)     state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_comb begin
    sum       = '0;
    spike_bit = '0;
    for (int i = 0; i < NUM_PES; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, pix_q[i]};
      if (mode_q) spike_bit[i] = (pix_q[i] != 8'd0) && (ttfs_step(pix_q[i]) == step);
      else        spike_bit[i] = sum[i][8];
    end
  end

  // Latched operands stay frozen for the whole train so later input changes are harmless.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      step   <= '0;
      pix_q  <= '0;
      acc    <= '0;
      mode_q <= 1'b0;
      spikes <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            pix_q  <= bus.pixels;
            mode_q <= bus.enc_mode;
            acc    <= '0;
            spikes <= '0;
            step   <= '0;
          end
        end
        ENCODE: begin
          for (int i = 0; i < NUM_PES; i++) begin
            spikes[i][step] <= spike_bit[i];
            acc[i]          <= sum[i][7:0];
          end
          step <= step + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == HOLD);
  assign bus.busy       = (state != IDLE);
  assign bus.out_spikes = spikes;
endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: reset abort, rate/TTFS vectors, backpressure,
// back-to-back transfers and input changes during encoding.
module tb_spike_encoder;
  localparam int NUM_PES = 4;
  localparam int T_STEPS = 8;

  logic clk;
  logic nrst;
  int   pass_cnt;
  int   total_cnt;

  spike_encoder_if #(.NUM_PES(NUM_PES), .T_STEPS(T_STEPS)) bus ();

  spike_encoder #(.NUM_PES(NUM_PES), .T_STEPS(T_STEPS)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply_stimulus(input logic [31:0] pix, input logic mode);
    bus.pixels   = pix;
    bus.enc_mode = mode;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_hold(input string tag, input int bound);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check(tag, bus.out_valid, 1'b1);
  endtask

  initial begin
    logic [31:0] held;
    pass_cnt      = 0;
    total_cnt     = 0;
    nrst          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.pixels    = '0;
    bus.enc_mode  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_spikes", bus.out_spikes, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    nrst = 1'b1;
    tick();
    check("rst_in_ready", bus.in_ready, 1'b1);

    // Abort a train three steps in; nothing partial may escape.
    apply_stimulus({8'd255, 8'd128, 8'd64, 8'd0}, 1'b0);
    tick(); tick(); tick();
    check("abort_busy_before", bus.busy, 1'b1);
    nrst = 1'b0;
    #2;
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_out_spikes", bus.out_spikes, 32'h0);
    check("abort_busy", bus.busy, 1'b0);
    nrst = 1'b1;
    tick();
    check("abort_in_ready", bus.in_ready, 1'b1);

    // Rate coding with exact latency.
    apply_stimulus({8'd255, 8'd128, 8'd64, 8'd0}, 1'b0);
    for (int i = 0; i < T_STEPS - 1; i++) tick();
    check("rate_not_early", bus.out_valid, 1'b0);
    tick();
    check("rate_latency", bus.out_valid, 1'b1);
    check("rate_spikes", bus.out_spikes, 32'hFEAA8800);
    bus.out_ready = 1'b1;
    tick();
    check("rate_handshake_valid", bus.out_valid, 1'b0);
    check("rate_handshake_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b0;

    // Temporal coding, then backpressure in HOLD.
    apply_stimulus({8'd1, 8'd200, 8'd255, 8'd0}, 1'b1);
    wait_hold("ttfs_hold", 20);
    check("ttfs_spikes", bus.out_spikes, 32'h80020100);
    for (int l = 1; l < NUM_PES; l++)
      check("ttfs_one_hot", $countones(bus.out_spikes[l]), 1);
    held = bus.out_spikes;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.pixels   = 32'h12345678 + i;
      tick();
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_spikes_stable", bus.out_spikes, 32'h80020100);
      check("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", bus.out_valid, 1'b0);
    check("bp_release_ready", bus.in_ready, 1'b1);
    check("bp_spikes_kept", bus.out_spikes, held);
    bus.out_ready = 1'b0;

    // Back-to-back with in_valid held high and out_ready tied high.
    bus.out_ready = 1'b1;
    bus.pixels    = {4{8'd128}};
    bus.enc_mode  = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    check("b2b_first_accept", bus.busy, 1'b1);
    bus.pixels   = {4{8'd255}};
    bus.enc_mode = 1'b1;
    for (int i = 0; i < T_STEPS; i++) tick();
    check("b2b_first_valid", bus.out_valid, 1'b1);
    check("b2b_first_spikes", bus.out_spikes, 32'hAAAAAAAA);
    tick();
    check("b2b_gap_ready", bus.in_ready, 1'b1);
    check("b2b_gap_valid", bus.out_valid, 1'b0);
    tick();
    check("b2b_second_accept", bus.busy, 1'b1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < T_STEPS; i++) tick();
    check("b2b_second_valid", bus.out_valid, 1'b1);
    check("b2b_second_spikes", bus.out_spikes, 32'h01010101);
    tick();
    check("b2b_second_done", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

    // Inputs churn during ENCODE; only the latched vector counts.
    apply_stimulus({8'd224, 8'd160, 8'd96, 8'd32}, 1'b0);
    for (int i = 0; i < T_STEPS; i++) begin
      bus.pixels   = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h01010101;
      bus.enc_mode = ~bus.enc_mode;
      tick();
    end
    check("churn_valid", bus.out_valid, 1'b1);
    check("churn_spikes", bus.out_spikes, 32'hFEDAA480);
    bus.out_ready = 1'b1;
    tick();
    check("churn_done", bus.in_ready, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
